// File: rtl/trng_postproc.sv
// trng_postproc: 2-flop sync and XOR-fold of the 16-lane sampler vector, repetition-count health test,
// optional von Neumann debiasing (compiled in with TRNG_VN_EN), 32-bit LSB-first packer with valid/ready.
module trng_postproc #(
    parameter int REP_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] raw,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        health_fail
);
    localparam logic [7:0] RUN_LIM = 8'(REP_LIMIT);

    logic [15:0] sync1, sync2;
    logic        fbit, fvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            fbit   <= 1'b0;
            fvalid <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            fbit   <= ^sync2;
            fvalid <= en;
        end
    end

    // Repetition-count health test on the folded stream
    logic [7:0] run_cnt;
    logic       last_bit;
    logic       trip, fail_now;

    assign trip     = (run_cnt == RUN_LIM);
    assign fail_now = health_fail | trip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= 8'd0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (trip)
                health_fail <= 1'b1;
            if (!fvalid) begin
                run_cnt <= 8'd0;
            end else begin
                last_bit <= fbit;
                if (run_cnt == 8'd0 || fbit != last_bit)
                    run_cnt <= 8'd1;
                else if (run_cnt != 8'hFF)
                    run_cnt <= run_cnt + 8'd1;
            end
        end
    end

    logic dbit, dvalid;

`ifdef TRNG_VN_EN
    logic phase, first_bit;

    // Non-overlapping pairs; (0,1)->0, (1,0)->1, equal pairs are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 1'b0;
            first_bit <= 1'b0;
            dbit      <= 1'b0;
            dvalid    <= 1'b0;
        end else if (!fvalid) begin
            phase  <= 1'b0;
            dvalid <= 1'b0;
        end else if (!phase) begin
            phase     <= 1'b1;
            first_bit <= fbit;
            dvalid    <= 1'b0;
        end else begin
            phase  <= 1'b0;
            dvalid <= first_bit ^ fbit;
            dbit   <= first_bit;
        end
    end
`else
    assign dbit   = fbit;
    assign dvalid = fvalid;
`endif

    // Packer and holding register
    logic [31:0] pack;
    logic [5:0]  count;
    logic [31:0] hold;
    logic        hold_valid;
    logic        full, drain, load;

    assign out_valid = hold_valid & ~health_fail;
    assign out_data  = hold;
    assign drain     = out_valid & out_ready;
    assign full      = (count == 6'd32);
    assign load      = full & (~hold_valid | drain) & ~fail_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack       <= '0;
            count      <= 6'd0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (fail_now) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (load) begin
                hold       <= pack;
                hold_valid <= 1'b1;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
            // A bit arriving in the load cycle becomes bit 0 of the next word
            if (load) begin
                pack  <= {31'd0, dbit & dvalid};
                count <= dvalid ? 6'd1 : 6'd0;
            end else if (dvalid && !full) begin
                pack[count[4:0]] <= dbit;
                count            <= count + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_trng_postproc.sv
// Self-checking bench for trng_postproc: bit-queue reference model plus scenario tasks.
module tb_trng_postproc;
    localparam int REP_LIMIT = 16;
`ifdef TRNG_VN_EN
    localparam int          FIRST_LAT = 69;
    localparam int          PERIOD    = 64;
    localparam logic [31:0] ALT_WORD  = 32'hFFFFFFFF;
`else
    localparam int          FIRST_LAT = 36;
    localparam int          PERIOD    = 32;
    localparam logic [31:0] ALT_WORD  = 32'h55555555;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] raw = 16'h0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        health_fail;
    int          total = 0;
    int          bad = 0;

    trng_postproc #(.REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .rst(rst), .en(en), .raw(raw), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Reference model: the packer is a queue of bits, words are built from it on demand
    bit [15:0] m_s1, m_s2;
    bit        m_fb, m_fv, m_last, m_health, m_phase, m_first, m_db, m_dv, m_hv;
    int        m_run;
    bit        pk[$];
    bit [31:0] m_hold;

    function automatic bit [31:0] pk_word();
        bit [31:0] w = 32'h0;
        foreach (pk[i]) w[i] = pk[i];
        return w;
    endfunction

    function automatic bit exp_valid();
        return m_hv && !m_health;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_fb = 0; m_fv = 0; m_last = 0; m_health = 0;
            m_phase = 0; m_first = 0; m_db = 0; m_dv = 0; m_hv = 0; m_run = 0;
            m_hold = 0; pk.delete();
        end else begin
            bit cdb, cdv, trip, fail, drain;
`ifdef TRNG_VN_EN
            cdb = m_db; cdv = m_dv;
`else
            cdb = m_fb; cdv = m_fv;
`endif
            trip  = (m_run == REP_LIMIT);
            fail  = m_health || trip;
            drain = m_hv && !m_health && out_ready;
            if (fail) begin
                m_hv = 0; m_hold = 0;
            end else if (pk.size() == 32 && (!m_hv || drain)) begin
                m_hold = pk_word(); m_hv = 1; pk.delete();
                if (cdv) pk.push_back(cdb);
            end else begin
                if (drain) m_hv = 0;
                if (cdv && pk.size() < 32) pk.push_back(cdb);
            end
            if (trip) m_health = 1;
            if (!m_fv) m_run = 0;
            else if (m_run != 0 && m_fb == m_last) m_run = (m_run < 255) ? m_run + 1 : 255;
            else m_run = 1;
            if (m_fv) m_last = m_fb;
            if (!m_fv) begin
                m_phase = 0; m_dv = 0;
            end else if (!m_phase) begin
                m_phase = 1; m_first = m_fb; m_dv = 0;
            end else begin
                m_phase = 0; m_dv = m_first ^ m_fb; m_db = m_first;
            end
            m_fb = ^m_s2; m_fv = en; m_s2 = m_s1; m_s1 = raw;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; out_ready = 0; raw = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        bit hit = 0;
        int first = 0;
        rst = 1; #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || health_fail !== 1'b0) begin
            bad++; $display("FAIL reset_init: got v=%b d=%h hf=%b, want 0 0 0", out_valid, out_data, health_fail);
        end
        @(negedge clk); rst = 0; raw = 16'h0001; en = 0; out_ready = 0;
        for (int c = 1; c <= 200 && !hit; c++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid !== exp_valid() || out_data !== m_hold || health_fail !== m_health) begin
                bad++; $display("FAIL reset_fill c=%0d: got v=%b d=%h hf=%b, want v=%b d=%h hf=%b",
                                c, out_valid, out_data, health_fail, exp_valid(), m_hold, m_health);
            end
            raw = (c % 2 == 0) ? 16'h0001 : 16'h0000; en = (c >= 2);
            if (m_hv && pk.size() == 17) hit = 1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL reset_setup: held word with count 17 not reached, want reached"); end
        #2 rst = 1; #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || health_fail !== 1'b0) begin
            bad++; $display("FAIL reset_async: got v=%b d=%h hf=%b, want 0 0 0", out_valid, out_data, health_fail);
        end
        @(negedge clk); rst = 0; raw = 16'h0001; en = 0; out_ready = 1;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid === 1'b1 && first == 0) first = c;
            raw = (c % 2 == 0) ? 16'h0001 : 16'h0000; en = (c >= 2);
        end
        total++;
        if (first != FIRST_LAT) begin
            bad++; $display("FAIL reset_first_word: got first valid at cycle %0d, want %0d", first, FIRST_LAT);
        end
    endtask

    task automatic test_pack();
        bit ev;
        do_reset(); raw = 16'h0001; out_ready = 1;
        for (int c = 1; c <= FIRST_LAT + 3 * PERIOD + 5; c++) begin
            @(posedge clk); @(negedge clk);
            ev = (c >= FIRST_LAT) && ((c - FIRST_LAT) % PERIOD == 0);
            total++;
            if (out_valid !== ev || (ev && out_data !== ALT_WORD) || health_fail !== 1'b0) begin
                bad++; $display("FAIL pack c=%0d: got v=%b d=%h hf=%b, want v=%b d=%h hf=0",
                                c, out_valid, out_data, health_fail, ev, ALT_WORD);
            end
            raw = (c % 2 == 0) ? 16'h0001 : 16'h0000; en = (c >= 2);
        end
    endtask

    task automatic test_debias();
        bit ev;
        do_reset(); raw = 16'h0001; out_ready = 1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid !== exp_valid() || out_data !== m_hold || health_fail !== m_health) begin
                bad++; $display("FAIL debias_model c=%0d: got v=%b d=%h, want v=%b d=%h", c, out_valid, out_data, exp_valid(), m_hold);
            end
`ifdef TRNG_VN_EN
            ev = 1'b0;
`else
            ev = (c >= 36) && ((c - 36) % 32 == 0);
`endif
            total++;
            if (out_valid !== ev || (ev && out_data !== 32'h33333333)) begin
                bad++; $display("FAIL debias_pairs c=%0d: got v=%b d=%h, want v=%b d=33333333", c, out_valid, out_data, ev);
            end
            raw = ((c / 2) % 2 == 0) ? 16'h0001 : 16'h0000; en = (c >= 2);
        end
    endtask

    task automatic test_health();
        do_reset(); raw = 16'hFFFF; out_ready = 1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (health_fail !== (c >= 20) || out_valid !== 1'b0) begin
                bad++; $display("FAIL health_trip c=%0d: got hf=%b v=%b, want hf=%b v=0", c, health_fail, out_valid, c >= 20);
            end
            en = (c >= 2);
        end
        for (int c = 1; c <= 80; c++) begin
            raw = (c % 2 == 0) ? 16'h0001 : 16'h0000;
            @(posedge clk); @(negedge clk);
            total++;
            if (health_fail !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
                bad++; $display("FAIL health_sticky c=%0d: got hf=%b v=%b d=%h, want 1 0 0", c, health_fail, out_valid, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        bit [31:0] a, b;
        bit hit = 0;
        do_reset(); raw = 16'($urandom()); out_ready = 0;
        for (int c = 1; c <= 120 && !hit; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom()); en = (c >= 2);
            if (m_hv) hit = 1;
        end
        a = m_hold;
        total++;
        if (!hit || out_valid !== 1'b1 || out_data !== a) begin
            bad++; $display("FAIL bp_first: got v=%b d=%h, want v=1 d=%h (reached=%b)", out_valid, out_data, a, hit);
        end
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom());
            total++;
            if (out_valid !== 1'b1 || out_data !== a) begin
                bad++; $display("FAIL bp_hold_a c=%0d: got v=%b d=%h, want v=1 d=%h", c, out_valid, out_data, a);
            end
        end
        b = pk_word();
        total++;
        if (pk.size() != 32) begin bad++; $display("FAIL bp_full: got model count %0d, want 32", pk.size()); end
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0; raw = 16'($urandom());
        total++;
        if (out_valid !== 1'b1 || out_data !== b) begin
            bad++; $display("FAIL bp_swap: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, b);
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom());
            total++;
            if (out_valid !== 1'b1 || out_data !== b) begin
                bad++; $display("FAIL bp_hold_b c=%0d: got v=%b d=%h, want v=1 d=%h", c, out_valid, out_data, b);
            end
        end
        out_ready = 1;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom());
            total++;
            if (out_valid !== exp_valid() || out_data !== m_hold || health_fail !== m_health) begin
                bad++; $display("FAIL bp_resume c=%0d: got v=%b d=%h, want v=%b d=%h", c, out_valid, out_data, exp_valid(), m_hold);
            end
        end
    endtask

    task automatic test_en_gating();
        bit seen = 0, hit = 0;
        bit [31:0] saved, mask;
        int s, lat = 0;
        do_reset(); raw = 16'($urandom()); out_ready = 1;
        for (int c = 1; c <= 200 && !hit; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom()); en = (c >= 2);
            if (out_valid === 1'b1) seen = 1;
            if (seen && pk.size() == 19) hit = 1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL en_setup: count 19 not reached, want reached"); end
        en = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom());
            total++;
            if (out_valid !== exp_valid() || out_data !== m_hold) begin
                bad++; $display("FAIL en_idle c=%0d: got v=%b d=%h, want v=%b d=%h", c, out_valid, out_data, exp_valid(), m_hold);
            end
        end
        saved = pk_word(); s = pk.size(); mask = 32'h0;
        for (int i = 0; i < s; i++) mask[i] = 1'b1;
        en = 1;
        for (int k = 1; k <= 120 && lat == 0; k++) begin
            @(posedge clk); @(negedge clk);
            raw = 16'($urandom());
            if (out_valid === 1'b1) lat = k;
        end
        total++;
        if (lat == 0 || (out_data & mask) !== (saved & mask)) begin
            bad++; $display("FAIL en_retain: got d=%h, want low %0d bits of %h (lat=%0d)", out_data, s, saved, lat);
        end
`ifndef TRNG_VN_EN
        total++;
        if (lat != 14) begin bad++; $display("FAIL en_latency: got %0d cycles, want 14", lat); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 3000; c++) begin
            raw = 16'($urandom()); en = ($urandom_range(9) != 0); out_ready = ($urandom_range(2) != 0);
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid !== exp_valid() || out_data !== m_hold || health_fail !== m_health) begin
                bad++; $display("FAIL random c=%0d: got v=%b d=%h hf=%b, want v=%b d=%h hf=%b",
                                c, out_valid, out_data, health_fail, exp_valid(), m_hold, m_health);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_debias();
        test_health();
        test_backpressure();
        test_en_gating();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
